audio_pll_supervisor: RTL and testbench

AUDIO_PLL_SUPERVISOR -- requirements
Module: audio_pll_supervisor

---
 rtl/audio_pll_sup_pkg.sv | 25 ++
 rtl/audio_sync_2ff.sv | 23 ++
 rtl/audio_pll_supervisor.sv | 145 ++++++++++++++
 tb/tb_audio_pll_supervisor.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pll_sup_pkg.sv
// Shared types and default timing constants for the audio PLL supervisor.
// State encoding is visible on the debug port, so the values are fixed.
package audio_pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLL_RST   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } sup_state_t;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 50000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/audio_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL lock flag into refclk.
module audio_sync_2ff
  import audio_pll_sup_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/audio_pll_supervisor.sv
// Brings up the audio PLL: reset pulse, bounded wait for lock, stability
// window, then releases audio reset; retries failed attempts before faulting.
module audio_pll_supervisor
  import audio_pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       audio_rst,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [7:0] lost_lock_count,
  output logic [2:0] state
);

  localparam int TW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

  // Each phase ends on the last cycle of its window, so the timer never wraps.
  localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRIES);

  sup_state_t    st, st_n;
  logic [TW-1:0] timer, timer_n;
  logic [1:0]    retry_n;
  logic [7:0]    lost_n;
  logic          locked_s;
  logic          fail;

  audio_sync_2ff u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  always_comb begin
    st_n    = st;
    timer_n = timer;
    retry_n = retry_count;
    lost_n  = lost_lock_count;
    fail    = 1'b0;

    if (!enable) begin
      st_n    = ST_IDLE;
      timer_n = '0;
      retry_n = '0;
    end else begin
      case (st)
        ST_IDLE: begin
          st_n    = ST_PLL_RST;
          timer_n = '0;
          retry_n = '0;
        end
        ST_PLL_RST: begin
          if (timer == RST_LAST) begin
            st_n    = ST_WAIT_LOCK;
            timer_n = '0;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock wins over a coincident timeout.
          if (locked_s) begin
            st_n    = ST_SETTLE;
            timer_n = '0;
          end else if (timer == TIMEOUT_LAST) begin
            fail = 1'b1;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (!locked_s) begin
            fail = 1'b1;
          end else if (timer == STABLE_LAST) begin
            st_n    = ST_RUN;
            timer_n = '0;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            st_n    = ST_PLL_RST;
            timer_n = '0;
            retry_n = '0;
            if (lost_lock_count != 8'hFF) lost_n = lost_lock_count + 8'd1;
          end
        end
        ST_FAULT: st_n = ST_FAULT;
        default: begin
          st_n    = ST_IDLE;
          timer_n = '0;
        end
      endcase

      if (fail) begin
        timer_n = '0;
        if (retry_count < RETRY_MAX) begin
          retry_n = retry_count + 2'd1;
          st_n    = ST_PLL_RST;
        end else begin
          st_n = ST_FAULT;
        end
      end
    end
  end

  // Outputs are registered from the next state so they line up with st.
  always_ff @(posedge refclk) begin
    if (rst) begin
      st              <= ST_IDLE;
      timer           <= '0;
      retry_count     <= '0;
      lost_lock_count <= '0;
      pll_rst         <= 1'b1;
      audio_rst       <= 1'b1;
      ready           <= 1'b0;
      fault           <= 1'b0;
    end else begin
      st              <= st_n;
      timer           <= timer_n;
      retry_count     <= retry_n;
      lost_lock_count <= lost_n;
      pll_rst         <= (st_n == ST_IDLE) || (st_n == ST_PLL_RST) || (st_n == ST_FAULT);
      audio_rst       <= (st_n != ST_RUN);
      ready           <= (st_n == ST_RUN);
      fault           <= (st_n == ST_FAULT);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_audio_pll_supervisor.sv
// Bench for audio_pll_supervisor: directed bring-up scenarios plus random
// stimulus, every cycle compared against a phase-counting reference model.
module tb_audio_pll_supervisor;

  localparam int P_RST     = 4;
  localparam int P_TIMEOUT = 20;
  localparam int P_STABLE  = 8;
  localparam int P_RETRIES = 2;

  localparam int M_IDLE = 0, M_PLL_RST = 1, M_WAIT = 2, M_SETTLE = 3, M_RUN = 4, M_FAULT = 5;

  // Handshake-free block: inputs change after the falling edge, DUT samples on
  // the rising edge, outputs are compared on the following falling edge.
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, audio_rst, ready, fault;
  logic [1:0] retry_count;
  logic [7:0] lost_lock_count;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  int m_state = M_IDLE;
  int m_cnt   = 0;
  int m_retry = 0;
  int m_lost  = 0;
  int sync_q[$];
  logic [16:0] exp_q[$];

  audio_pll_supervisor #(
    .RST_CYCLES    (P_RST),
    .LOCK_TIMEOUT  (P_TIMEOUT),
    .STABLE_CYCLES (P_STABLE),
    .MAX_RETRIES   (P_RETRIES)
  ) dut (
    .refclk          (clk),
    .rst             (rst),
    .enable          (enable),
    .pll_locked      (pll_locked),
    .pll_rst         (pll_rst),
    .audio_rst       (audio_rst),
    .ready           (ready),
    .fault           (fault),
    .retry_count     (retry_count),
    .lost_lock_count (lost_lock_count),
    .state           (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: counts cycles spent in each phase against the windows.
  task automatic model_fail();
    m_cnt = 0;
    if (m_retry < P_RETRIES) begin
      m_retry++;
      m_state = M_PLL_RST;
    end else begin
      m_state = M_FAULT;
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic l);
    int ls;
    if (r) begin
      m_state = M_IDLE; m_cnt = 0; m_retry = 0; m_lost = 0;
      sync_q.delete();
      sync_q.push_back(0);
      sync_q.push_back(0);
      return;
    end
    ls = sync_q.pop_front();
    sync_q.push_back(int'(l));
    if (!e) begin
      m_state = M_IDLE; m_cnt = 0; m_retry = 0;
      return;
    end
    case (m_state)
      M_IDLE: begin m_state = M_PLL_RST; m_cnt = 0; m_retry = 0; end
      M_PLL_RST: begin
        m_cnt++;
        if (m_cnt == P_RST) begin m_state = M_WAIT; m_cnt = 0; end
      end
      M_WAIT: begin
        if (ls != 0) begin m_state = M_SETTLE; m_cnt = 0; end
        else begin
          m_cnt++;
          if (m_cnt == P_TIMEOUT) model_fail();
        end
      end
      M_SETTLE: begin
        if (ls == 0) model_fail();
        else begin
          m_cnt++;
          if (m_cnt == P_STABLE) begin m_state = M_RUN; m_cnt = 0; end
        end
      end
      M_RUN: begin
        if (ls == 0) begin
          if (m_lost < 255) m_lost++;
          m_retry = 0; m_state = M_PLL_RST; m_cnt = 0;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [16:0] model_vec();
    logic prst;
    prst = (m_state == M_IDLE) || (m_state == M_PLL_RST) || (m_state == M_FAULT);
    return {3'(m_state), prst, (m_state != M_RUN), (m_state == M_RUN), (m_state == M_FAULT),
            2'(m_retry), 8'(m_lost)};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {state, pll_rst, audio_rst, ready, fault, retry_count, lost_lock_count};
  endfunction

  task automatic step(input logic r, input logic e, input logic l);
    rst = r; enable = e; pll_locked = l;
    @(posedge clk);
    model_step(r, e, l);
    exp_q.push_back(model_vec());
    @(negedge clk);
    check("cycle", 32'(dut_vec()), 32'(exp_q.pop_front()));
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input logic l, input int budget);
    int n;
    n = 0;
    while (state !== st && n < budget) begin
      step(1'b0, 1'b1, l);
      n++;
    end
    check(tag, 32'(state), 32'(st));
  endtask

  initial begin
    int lat;
    logic lvl;
    sync_q.push_back(0);
    sync_q.push_back(0);

    // Reset values
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("rst_state", 32'(state), 32'd0);
    check("rst_pll_rst", 32'(pll_rst), 32'd1);
    check("rst_audio_rst", 32'(audio_rst), 32'd1);
    check("rst_ready", 32'(ready), 32'd0);

    // Clean bring-up: lock rises 5 cycles after pll_rst falls
    wait_state("up_wait_lock", 3'd2, 1'b0, 20);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    lat = 0;
    do begin
      step(1'b0, 1'b1, 1'b1);
      lat++;
    end while (ready !== 1'b1 && lat < 40);
    check("ready_latency", 32'(lat), 32'd11);
    check("up_audio_rst", 32'(audio_rst), 32'd0);
    check("up_retry", 32'(retry_count), 32'd0);

    // One-cycle lock loss while running
    step(1'b0, 1'b1, 1'b0);
    wait_state("loss_pll_rst", 3'd1, 1'b1, 10);
    check("loss_audio_rst", 32'(audio_rst), 32'd1);
    check("loss_ready", 32'(ready), 32'd0);
    check("loss_count", 32'(lost_lock_count), 32'd1);
    wait_state("loss_relock", 3'd4, 1'b1, 60);
    check("loss_relock_ready", 32'(ready), 32'd1);

    // Glitch during the stability window
    step(1'b0, 1'b0, 1'b1);
    wait_state("glitch_settle", 3'd3, 1'b1, 30);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    wait_state("glitch_pll_rst", 3'd1, 1'b1, 10);
    check("glitch_retry", 32'(retry_count), 32'd1);
    wait_state("glitch_run", 3'd4, 1'b1, 60);
    check("glitch_ready", 32'(ready), 32'd1);

    // Lock never arrives: retries exhausted
    step(1'b0, 1'b0, 1'b0);
    wait_state("fault_enter", 3'd5, 1'b0, 200);
    check("fault_flag", 32'(fault), 32'd1);
    check("fault_retry", 32'(retry_count), 32'd2);
    check("fault_pll_rst", 32'(pll_rst), 32'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
    check("fault_sticky", 32'(fault), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("fault_clear_state", 32'(state), 32'd0);
    check("fault_clear_flag", 32'(fault), 32'd0);

    // Reset mid-settle, then enable drop in WAIT_LOCK
    wait_state("abort_settle", 3'd3, 1'b1, 30);
    step(1'b1, 1'b1, 1'b1);
    check("abort_state", 32'(state), 32'd0);
    check("abort_outputs", 32'({pll_rst, audio_rst, ready, fault}), 32'b1100);
    check("abort_counts", 32'({retry_count, lost_lock_count}), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    wait_state("abort_wait_lock", 3'd2, 1'b0, 20);
    step(1'b0, 1'b0, 1'b0);
    check("disable_state", 32'(state), 32'd0);
    check("disable_outputs", 32'({pll_rst, audio_rst, ready, fault, retry_count}), 32'b110000);

    // 257 lock losses saturate the counter
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 257; i++) begin
      wait_state("sat_run", 3'd4, 1'b1, 60);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
    end
    check("sat_count", 32'(lost_lock_count), 32'd255);

    // Random traffic against the model
    lvl = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) lvl = ~lvl;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 79) != 0), lvl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
